// File: rtl/gray_bin_thresh.sv
// gray_bin_thresh: grayscale pixel stream to 1-bit stream binariser.
//
// Four threshold modes (0 at-or-above L, 1 below L, 2 band L..H,
// 3 row-aware hysteresis). Thresholds and mode are latched on each accepted
// sop; the sop pixel itself uses the live inputs. One cycle of latency.
// Checks frame structure (stray pixels, early sop, pixel count) and pulses
// frame_err in the same cycle as the offending pixel's output slot.
//
// Optional feature macro: GRAY_BIN_ADAPTIVE_THR_EN
//   When defined, the min/max of each frame is tracked and, after a frame
//   that ends cleanly, modes 0 and 1 use (min+max)>>1 instead of L.
//
// Stream handshake: there is no backpressure. A pixel is transferred on every
// cycle where din_vld=1; din_sop/din_eop are only meaningful with din_vld.
// dout_vld marks each cycle carrying a classified in-frame pixel, and
// dout_sop/dout_eop are only ever asserted together with dout_vld.
// The FSM state is observable through busy (1 = ACTIVE).

module gray_bin_thresh #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int CNT_W  = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] thr_lo,
  input  logic [DATA_W-1:0] thr_hi,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  input  logic              din_sop,
  input  logic              din_eop,
  output logic              dout,
  output logic              dout_vld,
  output logic              dout_sop,
  output logic              dout_eop,
  output logic              frame_err,
  output logic              busy
);

  localparam int              COL_W     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] FRAME_PIX = CNT_W'(IMG_W * IMG_H);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Latched per-frame configuration
  logic [DATA_W-1:0] lo_q, hi_q;
  logic [1:0]        mode_q;

  // Position tracking
  logic [COL_W-1:0]  col_q;
  logic [CNT_W-1:0]  pix_cnt_q;
  logic              hyst_q;

  // Per-pixel decode
  logic              sop_acc, eop_acc, pix_take, stray, early_sop, count_bad;
  logic [DATA_W-1:0] eff_lo, eff_hi, ref01;
  logic [1:0]        eff_mode;
  logic [COL_W-1:0]  cur_col;
  logic [CNT_W-1:0]  cnt_inc;
  logic              hyst_prev;
  logic              cls;

`ifdef GRAY_BIN_ADAPTIVE_THR_EN
  logic [DATA_W-1:0] min_q, max_q, fmin, fmax, auto_thr_q;
  logic              auto_vld_q;
  logic [DATA_W:0]   mm_sum;
`endif

  // Framing decode for the pixel presented this cycle
  always_comb begin
    sop_acc   = din_vld & din_sop;
    eop_acc   = din_vld & din_eop;
    pix_take  = din_vld & ((state == ACTIVE) | din_sop);
    stray     = din_vld & (state == IDLE) & ~din_sop;
    early_sop = sop_acc & (state == ACTIVE);
    cur_col   = sop_acc ? '0 : col_q;
    if (sop_acc) begin
      cnt_inc = CNT_ONE;
    end else if (pix_cnt_q == CNT_MAX) begin
      cnt_inc = CNT_MAX;
    end else begin
      cnt_inc = pix_cnt_q + CNT_ONE;
    end
    count_bad = eop_acc & pix_take & (cnt_inc != FRAME_PIX);
  end

  // Effective config: sop pixel sees the live inputs, the rest the latched copy
  always_comb begin
    eff_lo   = sop_acc ? thr_lo : lo_q;
    eff_hi   = sop_acc ? thr_hi : hi_q;
    eff_mode = sop_acc ? mode   : mode_q;
`ifdef GRAY_BIN_ADAPTIVE_THR_EN
    ref01    = auto_vld_q ? auto_thr_q : eff_lo;
`else
    ref01    = eff_lo;
`endif
  end

  // Pixel classification; hysteresis memory restarts at every row start
  always_comb begin
    hyst_prev = (cur_col == '0) ? 1'b0 : hyst_q;
    cls       = 1'b0;
    case (eff_mode)
      2'd0: cls = (din >= ref01);
      2'd1: cls = (din < ref01);
      2'd2: cls = (din >= eff_lo) && (din <= eff_hi);
      default: begin
        if (din >= eff_hi) begin
          cls = 1'b1;
        end else if (din < eff_lo) begin
          cls = 1'b0;
        end else begin
          cls = hyst_prev;
        end
      end
    endcase
  end

  // Next-state logic; a combined sop+eop pixel is a whole frame and stays IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (sop_acc && !din_eop) begin
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (eop_acc) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign busy = (state == ACTIVE);

  // Config latch on every accepted sop (including an early restart)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q   <= '0;
      hi_q   <= '0;
      mode_q <= '0;
    end else if (sop_acc) begin
      lo_q   <= thr_lo;
      hi_q   <= thr_hi;
      mode_q <= mode;
    end
  end

  // Column, saturating pixel count and hysteresis memory
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q     <= '0;
      pix_cnt_q <= '0;
      hyst_q    <= 1'b0;
    end else if (pix_take) begin
      col_q     <= (cur_col == COL_LAST) ? '0 : cur_col + COL_W'(1);
      pix_cnt_q <= cnt_inc;
      hyst_q    <= cls;
    end
  end

  // Registered outputs; dout holds its value between valid pixels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout      <= 1'b0;
      dout_vld  <= 1'b0;
      dout_sop  <= 1'b0;
      dout_eop  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      dout_vld  <= pix_take;
      dout_sop  <= sop_acc;
      dout_eop  <= eop_acc & pix_take;
      frame_err <= stray | early_sop | count_bad;
      if (pix_take) begin
        dout <= cls;
      end
    end
  end

`ifdef GRAY_BIN_ADAPTIVE_THR_EN
  // Frame extremes including the current pixel, and their midpoint
  always_comb begin
    fmin   = sop_acc ? din : ((din < min_q) ? din : min_q);
    fmax   = sop_acc ? din : ((din > max_q) ? din : max_q);
    mm_sum = {1'b0, fmin} + {1'b0, fmax};
  end

  // Track extremes and publish the midpoint after a cleanly ended frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q      <= '0;
      max_q      <= '0;
      auto_thr_q <= '0;
      auto_vld_q <= 1'b0;
    end else if (pix_take) begin
      min_q <= fmin;
      max_q <= fmax;
      if (eop_acc && !count_bad) begin
        auto_thr_q <= mm_sum[DATA_W:1];
        auto_vld_q <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/gray_bin_thresh.md
Name: gray_bin_thresh

Overview:
- Parametrised successor to the single-threshold grayscale binariser in the edge-detection pipeline.
- Converts a DATA_W-bit grayscale pixel stream (vld/sop/eop framing) into a 1-bit stream.
- Four threshold modes; configuration is latched per frame.
- Row-aware hysteresis, frame-structure checking, and vld-qualified framing outputs.

Parameters:
- DATA_W, 8: pixel width in bits.
- IMG_W, 640: pixels per row; used for the column counter and hysteresis row reset.
- IMG_H, 480: rows per frame; expected pixel count is IMG_W*IMG_H.
- CNT_W, 20: width of the frame pixel counter. Must satisfy 2^CNT_W > IMG_W*IMG_H.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- thr_lo  in  DATA_W  low threshold.
- thr_hi  in  DATA_W  high threshold.
- mode  in  2  0=at-or-above, 1=below, 2=band, 3=hysteresis.
- din  in  DATA_W  pixel data.
- din_vld  in  1  pixel valid.
- din_sop  in  1  first pixel of frame; meaningful only with din_vld.
- din_eop  in  1  last pixel of frame; meaningful only with din_vld.
- dout  out  1  binary pixel.
- dout_vld  out  1  output valid.
- dout_sop  out  1  output start of frame.
- dout_eop  out  1  output end of frame.
- frame_err  out  1  one-cycle error pulse.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Reset: clk and rst_n as already decided (reset rst_n, asynchronous, active-low; clock clk). All outputs reset to 0; FSM in IDLE; counters and config registers reset to 0.
- Accept: a pixel is accepted when din_vld=1. There is no backpressure.
- FSM states IDLE and ACTIVE:
  - IDLE -> ACTIVE on accepted sop.
  - ACTIVE -> IDLE on accepted eop.
  - sop and eop on the same pixel: a one-pixel frame; FSM stays in IDLE.
  - busy = (state==ACTIVE).
- Config latch: on an accepted sop, thr_lo, thr_hi and mode are registered. The sop pixel itself uses the new values, bypassed directly from the inputs. Input changes mid-frame have no effect.
- Classification, where L and H are the latched thresholds, compared unsigned:
  - mode 0: dout = din >= L.
  - mode 1: dout = din < L.
  - mode 2: dout = (L <= din <= H). If L > H, the result is always 0.
  - mode 3: dout = 1 if din >= H; else 0 if din < L; else the previous dout of the same row. Check order is >= H first, so L > H is well defined.
- Hysteresis state is cleared to 0 at column 0 of every row.
- Column counter: wraps at IMG_W-1 -> 0 and is cleared on accepted sop.
- Latency: exactly 1 cycle. dout_vld = registered din_vld, but only for accepted in-frame pixels.
  - dout_sop = registered (din_vld & din_sop).
  - dout_eop = registered (din_vld & din_eop).
  - dout holds its last value when dout_vld=0.
- Stray pixel: an accepted pixel in IDLE without sop is dropped (dout_vld=0) and frame_err pulses.
- Early sop: an accepted sop while ACTIVE aborts the current frame, then restarts it. Config is relatched, counters are cleared, frame_err pulses, and the pixel is output with dout_sop=1.
- Pixel count mismatch: on accepted eop, if the pixel count including eop is not IMG_W*IMG_H, frame_err pulses in the cycle with dout_eop.
- Pixel counter saturates at its maximum value.
- Reset mid-frame: the block returns immediately to IDLE and no output is produced for the partial frame.

Optional Feature:
- Macro: GRAY_BIN_ADAPTIVE_THR_EN.
- Defined:
  - Track the min and max of din over each frame.
  - At an accepted eop with no frame_err for that frame, store auto_thr = (min+max)>>1, computed with a DATA_W+1-bit sum.
  - Modes 0 and 1 use auto_thr in place of L for the next frame.
  - Until the first valid frame completes after reset, L is used.
  - Modes 2 and 3 are unchanged.
- Undefined: no min/max logic is present, and modes 0 and 1 always use L.

Test Plan:
- Mode 0, L=128, 4x2 frame, din=127,128,0,255,...: dout=0,1,0,1 with 1-cycle latency. dout_sop on the first pixel, dout_eop on the 8th, frame_err=0.
- Mode 2 band, L=50, H=100, din=49,50,100,101 -> dout=0,1,1,0. Repeat with L=100, H=50: all outputs 0.
- Mode 3, L=80, H=160, IMG_W=4, row 170,120,60,120 -> 1,1,0,0. The next row starting 120 -> 0, confirming the row reset.
- din_vld with no sop in IDLE -> dout_vld=0 and frame_err pulse. A sop at pixel 3 of a frame -> frame_err pulse and dout_sop=1.
- eop after 7 pixels, with IMG_W*IMG_H=8 -> frame_err pulse coincident with dout_eop. Changing thr_lo mid-frame leaves outputs unaffected.
- GRAY_BIN_ADAPTIVE_THR_EN, mode 0: frame 1 pixels span 20..220, so auto_thr=120. Frame 2 din=119,120 -> dout=0,1. Reset mid-frame 2 -> all outputs 0 and busy=0.
